// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register feeding a first-word-fall-through fetch buffer toward decode.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_cnt_o push counter.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_en_o,
   input  logic [31:0] imem_instr_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] fetch_cnt_o
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [63:0]      buf_mem [FIFO_DEPTH];

   logic pop_raw, pop, push, full;

   always_comb begin
      pop_raw = valid_o & ready_i;
      full    = (count_q == CNT_W'(FIFO_DEPTH));
      push    = fetch_en_i & ~redirect_i & (~full | pop_raw);
      // A redirect flushes the buffer, so any pop requested in that cycle is void.
      pop     = pop_raw & ~redirect_i;

      pc_d    = pc_q;
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;

      if (redirect_i) begin
         pc_d    = {redirect_pc_i[31:2], 2'b00};
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         if (push) begin
            pc_d   = pc_q + 32'd4;
            tail_d = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= {RESET_PC[31:2], 2'b00};
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Storage is deliberately unreset; valid_o gating hides stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_mem[tail_q] <= {pc_q, imem_instr_i};
      end
   end

   assign imem_addr_o       = pc_q;
   assign imem_en_o         = push;
   assign valid_o           = (count_q != '0);
   assign {pc_o, instr_o}   = buf_mem[head_q];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (push) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
